mem_io_arbiter: RTL
===================

MEM_IO_ARBITER -- requirements
Module: mem_io_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra memory wait cycles after the access cycle; legal range 0..15.
REQ-002 clk  in  1  Rising-edge clock, the only clock.
REQ-003 rst  in  1  Reset; synchronous, active-high.
REQ-004 CPU_MIO  in  1  CPU (requester 0) request; held high until its transaction completes.
REQ-005 cpu_we, cpu_addr, cpu_wdata, cpu_ctrl  in  1, 32, 32, 3  CPU write flag, address, store data and RAMCtrl width code.
REQ-006 MIO_ready  out  1  1 = CPU may proceed; 0 = CPU suspends.
REQ-007 cpu_rdata  out  32  CPU read data, valid while MIO_ready is 1 after a CPU read.
REQ-008 dma_req, dma_we, dma_addr, dma_wdata, dma_ctrl  in  1, 1, 32, 32, 3  Requester 1 fields, same meaning as the CPU fields.
REQ-009 dma_ack  out  1  One-cycle completion pulse to requester 1.
REQ-010 dma_rdata  out  32  Requester 1 read data, valid while dma_ack is 1.
REQ-011 mem_en, mem_we  out  1, 1  Memory strobe and write enable.
REQ-012 mem_addr, mem_wdata, mem_ctrl  out  32, 32, 3  Latched address, data and width code.
REQ-013 mem_rdata  in  32  Memory read data; valid on the last wait cycle.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, WAIT and DONE, with one granted requester latched in a register named gnt.
REQ-015 In IDLE, if no request is active, the FSM SHALL stay in IDLE.
REQ-016 In IDLE, with exactly one request active, that requester SHALL be granted.
REQ-017 In IDLE, with both requests active, the requester not served last (register last_gnt) SHALL be granted.
REQ-018 On grant, the FSM SHALL latch we/addr/wdata/ctrl of the granted requester, update last_gnt, and go to ACCESS next cycle.
REQ-019 ACCESS SHALL last exactly 1 cycle, with mem_en=1, mem_we=latched we, and mem_addr/mem_wdata/mem_ctrl driven from the latches.
REQ-020 After ACCESS, the FSM SHALL go to WAIT if WAIT_CYCLES>0, else to DONE.
REQ-021 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-022 In WAIT, mem_en and mem_we SHALL be 0 and mem_addr/mem_wdata/mem_ctrl SHALL hold their latched values.
REQ-023 mem_rdata SHALL be captured into a read register on the final WAIT cycle, or in the ACCESS cycle when WAIT_CYCLES=0.
REQ-024 Captured read data SHALL be presented on cpu_rdata or dma_rdata per gnt.
REQ-025 DONE SHALL last 1 cycle and then return to IDLE.
REQ-026 In DONE with gnt=DMA, dma_ack SHALL be 1; dma_ack SHALL be 0 in all other cycles.
REQ-027 MIO_ready SHALL be 1 when CPU_MIO=0.
REQ-028 MIO_ready SHALL be 1 in DONE with gnt=CPU.
REQ-029 MIO_ready SHALL be 0 in all other cases.
REQ-030 Latency from request seen in IDLE (cycle N) to completion SHALL be DONE at cycle N+2+WAIT_CYCLES.
REQ-031 A request dropped mid-transaction SHALL NOT abort the transaction; it completes and signals completion normally.
REQ-032 Requests and request fields SHALL be sampled only in IDLE; changes during ACCESS/WAIT/DONE SHALL be ignored.
REQ-033 Back-to-back transactions SHALL be separated by at least one IDLE cycle.
REQ-034 Under continuous dual requests, grants SHALL alternate CPU, DMA, CPU, ...

Reset
REQ-035 While rst=1 at a clock edge, the next state SHALL be: FSM=IDLE, gnt=CPU, last_gnt=DMA (CPU wins the first tie), wait counter=0.
REQ-036 While rst=1 at a clock edge, the next state SHALL be: all latches and the read register=0.
REQ-037 After reset, all registered outputs (mem_en, mem_we, dma_ack, mem_addr, mem_wdata, mem_ctrl, cpu_rdata, dma_rdata) SHALL be 0.
REQ-038 After reset, MIO_ready SHALL follow REQ-027 to REQ-029.
REQ-039 Reset asserted mid-transaction SHALL abandon it: no mem_en and no dma_ack/MIO_ready completion pulse for it in the cycle after the reset edge.

Verification
REQ-040 Scenario: WAIT_CYCLES=1; CPU read addr 0x100, mem returns 0xDEADBEEF. Required: mem_en at N+1, MIO_ready=1 and cpu_rdata=0xDEADBEEF at N+3.
REQ-041 Scenario: DMA write addr 0x40, data 0x12345678, ctrl 3'b000. Required: one mem_en cycle with mem_we=1 and those values, dma_ack single pulse at N+3, MIO_ready=1 throughout (CPU_MIO=0).
REQ-042 Scenario: CPU_MIO and dma_req both held high for 4 transactions after reset. Required: grant order CPU, DMA, CPU, DMA, and MIO_ready=0 whenever the CPU is waiting outside DONE.
REQ-043 Scenario: WAIT_CYCLES=0, single CPU read. Required: DONE at N+2, read captured in ACCESS, no WAIT cycle.
REQ-044 Scenario: rst pulsed during WAIT of a DMA read. Required: FSM=IDLE, no dma_ack, and the next tie grants the CPU.
REQ-045 Scenario: cpu_addr changed during WAIT. Required: mem_addr holds the IDLE-latched value.

Source files
------------

// File: rtl/mem_io_arbiter.sv
// Two-requester (CPU, DMA) arbiter in front of a single-port memory with a fixed
// wait-state count. Ties go to whichever requester was not served last.
module mem_io_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_ctrl,
  output logic        MIO_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [2:0]  dma_ctrl,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  typedef enum logic {GNT_CPU = 1'b0, GNT_DMA = 1'b1} req_e;

  // Counter reload value; unused (and wrapped) when WAIT_CYCLES is 0.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  req_e        gnt, gnt_d;
  req_e        last_gnt, last_gnt_d;
  req_e        pick;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    gnt_d      = gnt;
    last_gnt_d = last_gnt;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    rdata_d    = rdata_q;
    pick       = GNT_CPU;

    if (CPU_MIO && dma_req) pick = (last_gnt == GNT_CPU) ? GNT_DMA : GNT_CPU;
    else if (dma_req)       pick = GNT_DMA;

    case (state_q)
      IDLE: begin
        if (CPU_MIO || dma_req) begin
          gnt_d      = pick;
          last_gnt_d = pick;
          we_d       = (pick == GNT_DMA) ? dma_we    : cpu_we;
          addr_d     = (pick == GNT_DMA) ? dma_addr  : cpu_addr;
          wdata_d    = (pick == GNT_DMA) ? dma_wdata : cpu_wdata;
          ctrl_d     = (pick == GNT_DMA) ? dma_ctrl  : cpu_ctrl;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (WAIT_CYCLES == 0) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: synchronous reset clears every register, including the data latches,
  // so the memory-side outputs read as zero right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= GNT_CPU;
      last_gnt <= GNT_DMA;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      last_gnt <= last_gnt_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
    end
  end

  // All outputs decode registered state only, except MIO_ready's bypass for an idle CPU.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ctrl  = ctrl_q;
  assign dma_ack   = (state_q == DONE) && (gnt == GNT_DMA);
  assign MIO_ready = !CPU_MIO || ((state_q == DONE) && (gnt == GNT_CPU));
  assign cpu_rdata = (gnt == GNT_CPU) ? rdata_q : '0;
  assign dma_rdata = (gnt == GNT_DMA) ? rdata_q : '0;

endmodule
